// File: rtl/md_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
// Requests are single-cycle strobes; busy/busy_any tell the hazard unit when to stall.
interface md_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             busy_any;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, A, B, input busy, busy_any, hi, lo);
  modport slave  (input start, op, A, B, output busy, busy_any, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle mult/div with HI/LO; result commits N edges after accept (N = MULT_/DIV_CYCLES).
// No queuing: start while busy is dropped, so the core must stall on busy_any.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic        clk,
  input logic        reset,
  md_unit_if.slave   md
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic [WIDTH-1:0] hi_q, lo_q, phi_q, plo_q;
  logic [WIDTH-1:0] res_hi_d, res_lo_d;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag;

  // Signed divide runs on magnitudes so MIN/-1 wraps to MIN without overflow hazards.
  always_comb begin
    prod_s = {{WIDTH{md.A[WIDTH-1]}}, md.A} * {{WIDTH{md.B[WIDTH-1]}}, md.B};
    prod_u = {{WIDTH{1'b0}}, md.A} * {{WIDTH{1'b0}}, md.B};
    a_neg  = md.A[WIDTH-1];
    b_neg  = md.B[WIDTH-1];
    a_mag  = a_neg ? -md.A : md.A;
    b_mag  = b_neg ? -md.B : md.B;
    q_mag  = '0;
    r_mag  = '0;
    if (md.B != '0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
  end

  // Divide by zero latches the current HI/LO, which cannot change while busy.
  always_comb begin
    res_hi_d = hi_q;
    res_lo_d = lo_q;
    case (md.op)
      OP_MULT:  {res_hi_d, res_lo_d} = prod_s;
      OP_MULTU: {res_hi_d, res_lo_d} = prod_u;
      OP_DIV: begin
        if (md.B != '0) begin
          res_lo_d = (a_neg ^ b_neg) ? -q_mag : q_mag;
          res_hi_d = a_neg ? -r_mag : r_mag;
        end
      end
      OP_DIVU: begin
        if (md.B != '0) begin
          res_lo_d = md.A / md.B;
          res_hi_d = md.A % md.B;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (md.start) begin
            case (md.op)
              OP_MTHI: hi_q <= md.A;
              OP_MTLO: lo_q <= md.A;
              OP_MULT, OP_MULTU: begin
                phi_q   <= res_hi_d;
                plo_q   <= res_lo_d;
                cnt_q   <= CW'(MULT_CYCLES);
                busy_q  <= 1'b1;
                state_q <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                phi_q   <= res_hi_d;
                plo_q   <= res_lo_d;
                cnt_q   <= CW'(DIV_CYCLES);
                busy_q  <= 1'b1;
                state_q <= RUN;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt_q == CW'(1)) begin
            hi_q    <= phi_q;
            lo_q    <= plo_q;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign md.busy     = busy_q;
  assign md.busy_any = busy_q | (md.start & (md.op <= OP_DIVU));
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Random + directed bench for md_unit against a cycle-numbered reference model
// built on 64-bit arithmetic.
module tb_md_unit;
  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;

  md_unit_if #(.WIDTH(W)) bus ();

  md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: commit is scheduled by absolute edge number.
  int          cyc    = 0;
  int          m_done = 0;
  bit          m_busy = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge(input logic s, input logic [2:0] o,
                            input logic [31:0] a, input logic [31:0] b, input logic r);
    longint          sa, sb, q, rm;
    longint unsigned pu;
    cyc++;
    if (!r) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0;
    end else if (m_busy) begin
      if (cyc == m_done) begin
        m_hi = p_hi; m_lo = p_lo; m_busy = 1'b0;
      end
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
        3'd0: begin q = sa * sb; {p_hi, p_lo} = q; end
        3'd1: begin pu = longint'({32'd0, a}) * longint'({32'd0, b}); {p_hi, p_lo} = pu; end
        3'd2: if (b == 0) begin p_hi = m_hi; p_lo = m_lo; end
              else begin q = sa / sb; rm = sa % sb; p_lo = q[31:0]; p_hi = rm[31:0]; end
        3'd3: if (b == 0) begin p_hi = m_hi; p_lo = m_lo; end
              else begin p_lo = a / b; p_hi = a % b; end
        3'd4: m_hi = a;
        3'd5: m_lo = a;
        default: ;
      endcase
      if (o <= 3'd3) begin
        m_busy = 1'b1;
        m_done = cyc + ((o <= 3'd1) ? MC : DC);
      end
    end
  endtask

  task automatic step(input logic s, input logic [2:0] o,
                      input logic [31:0] a, input logic [31:0] b, input logic r);
    bus.start = s; bus.op = o; bus.A = a; bus.B = b; reset = r;
    #1;
    check("busy_any", {63'd0, bus.busy_any}, {63'd0, m_busy | (s && o <= 3'd3)});
    @(posedge clk);
    model_edge(s, o, a, b, r);
    #1;
    check("hi",   {32'd0, bus.hi}, {32'd0, m_hi});
    check("lo",   {32'd0, bus.lo}, {32'd0, m_lo});
    check("busy", {63'd0, bus.busy}, {63'd0, m_busy});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd7, '0, '0, 1'b1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    bus.start = 1'b0; bus.op = 3'd7; bus.A = '0; bus.B = '0; reset = 1'b0;
    @(posedge clk); #1;
    step(1'b0, 3'd7, '0, '0, 1'b0);
    step(1'b0, 3'd7, '0, '0, 1'b0);

    step(1'b1, 3'd0, 32'hFFFF_FFFD, 32'h5, 1'b1);
    idle(MC);
    check("mult_hi", {32'd0, bus.hi}, 64'hFFFF_FFFF);
    check("mult_lo", {32'd0, bus.lo}, 64'hFFFF_FFF1);

    step(1'b1, 3'd1, 32'hFFFF_FFFF, 32'h2, 1'b1);
    idle(MC);
    check("multu_hi", {32'd0, bus.hi}, 64'h1);
    check("multu_lo", {32'd0, bus.lo}, 64'hFFFF_FFFE);

    step(1'b1, 3'd2, 32'hFFFF_FFF9, 32'h2, 1'b1);
    idle(DC);
    check("div_lo", {32'd0, bus.lo}, 64'hFFFF_FFFD);
    check("div_hi", {32'd0, bus.hi}, 64'hFFFF_FFFF);

    step(1'b1, 3'd4, 32'h1234_5678, 32'hDEAD, 1'b1);
    step(1'b1, 3'd5, 32'h9ABC_DEF0, 32'hBEEF, 1'b1);
    check("mthi", {32'd0, bus.hi}, 64'h1234_5678);
    check("mtlo", {32'd0, bus.lo}, 64'h9ABC_DEF0);

    step(1'b1, 3'd4, 32'h1, '0, 1'b1);
    step(1'b1, 3'd5, 32'h2, '0, 1'b1);
    step(1'b1, 3'd3, 32'h7, 32'h0, 1'b1);
    idle(DC);
    check("div0_hi", {32'd0, bus.hi}, 64'h1);
    check("div0_lo", {32'd0, bus.lo}, 64'h2);

    step(1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    idle(DC);
    check("divmin_lo", {32'd0, bus.lo}, 64'h8000_0000);
    check("divmin_hi", {32'd0, bus.hi}, 64'h0);

    step(1'b1, 3'd0, 32'h3, 32'h4, 1'b1);
    step(1'b1, 3'd5, 32'h55, '0, 1'b1);
    step(1'b1, 3'd0, 32'h7, 32'h7, 1'b1);
    idle(MC - 2);
    check("ignored_lo", {32'd0, bus.lo}, 64'hC);
    step(1'b1, 3'd1, 32'h9, 32'h9, 1'b1);
    idle(MC);
    check("b2b_lo", {32'd0, bus.lo}, 64'h51);

    step(1'b1, 3'd6, 32'hAAAA, 32'hBBBB, 1'b1);
    step(1'b1, 3'd7, 32'hCCCC, 32'hDDDD, 1'b1);

    step(1'b1, 3'd2, 32'd100, 32'd7, 1'b1);
    idle(2);
    step(1'b0, 3'd7, '0, '0, 1'b0);
    idle(DC);
    check("rst_hi", {32'd0, bus.hi}, 64'h0);
    check("rst_lo", {32'd0, bus.lo}, 64'h0);
    step(1'b1, 3'd0, 32'h5, 32'h5, 1'b0);
    check("rst_start_busy", {63'd0, bus.busy}, 64'h0);

    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), pick(), pick(),
           ($urandom_range(0, 99) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
